master_slave_jk: RTL and testbench



---
 rtl/master_slave_jk_if.sv | 15 +
 rtl/master_slave_jk.sv | 47 ++++
 tb/tb_master_slave_jk.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/master_slave_jk_if.sv
// master_slave_jk_if: J/K request and Q/Q-bar state bundle for master_slave_jk.
//   s      : J input (set request), driven by the requester
//   r      : K input (reset request), driven by the requester
//   qn     : flip-flop state Q, driven by the cell
//   qn_bar : complement of Q, driven by the cell
// Modports: master = side that drives s/r, slave = the flip-flop cell.
interface master_slave_jk_if;
  logic s;
  logic r;
  logic qn;
  logic qn_bar;

  modport master (output s, output r, input qn, input qn_bar);
  modport slave  (input s, input r, output qn, output qn_bar);
endinterface

// File: rtl/master_slave_jk.sv
// master_slave_jk: master-slave JK flip-flop, externally negative-edge triggered.
//   clk   : master latch transparent while high, slave loads on falling edge
//   rst_n : asynchronous active-low reset, clears master and slave
//   bus   : s (J), r (K) in; qn (Q), qn_bar (~Q) out
module master_slave_jk (
  input  logic                clk,
  input  logic                rst_n,
  master_slave_jk_if.slave    bus
);

  logic m;
  logic q;
  logic m_next;

  // JK table evaluated against the slave value; the slave is closed while the
  // master is open, so q is stable for the whole high phase (no race-around).
  always_comb begin
    m_next = q;
    case ({bus.s, bus.r})
      2'b00:   m_next = q;
      2'b01:   m_next = 1'b0;
      2'b10:   m_next = 1'b1;
      2'b11:   m_next = ~q;
      default: m_next = q;
    endcase
  end

  // Master stage: transparent while clk is high, holds while low.
  always_latch begin
    if (!rst_n)
      m <= 1'b0;
    else if (clk)
      m <= m_next;
  end

  // Slave stage: captures the closed master on the falling edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= 1'b0;
    else
      q <= m;
  end

  assign bus.qn     = q;
  assign bus.qn_bar = ~q;

endmodule

// File: tb/tb_master_slave_jk.sv
// tb_master_slave_jk: directed scenarios plus randomized J/K traffic and reset
// pulses, checked against a next-state lookup model sampled at falling edges.
module tb_master_slave_jk;

  logic clk;
  logic rst_n;
  int unsigned tests;
  int unsigned fails;

  master_slave_jk_if bus ();

  master_slave_jk dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Next Q indexed by {J, K, Q}: 000..111 -> 0,1,0,0,1,1,1,0
  logic [7:0] jk_tbl;
  logic       model_q;
  logic [2:0] idx;

  initial jk_tbl = 8'b0111_0010;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q = 1'b0;
    end else begin
      idx     = {bus.s, bus.r, model_q};
      model_q = jk_tbl[idx];
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: after every falling edge the outputs must match the model,
  // and a rising edge must leave them where they were.
  logic pre_rise;
  always @(negedge clk) begin
    #1;
    chk("fall_qn", bus.qn, model_q);
    chk("fall_qn_bar", bus.qn_bar, ~model_q);
  end

  always @(posedge clk) begin
    pre_rise = bus.qn;
    #1;
    chk("rise_no_change", bus.qn, pre_rise);
    chk("rise_model", bus.qn, model_q);
  end

  always @(bus.qn or bus.qn_bar) begin
    #1;
    chk("complement", bus.qn_bar, ~bus.qn);
  end

  task automatic step_check(input logic sv, input logic rv, input logic exp,
                            input string name);
    @(posedge clk); #2;
    bus.s = sv;
    bus.r = rv;
    @(negedge clk); #1;
    chk(name, bus.qn, exp);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.s = 1'b1;
    bus.r = 1'b0;

    // Reset held with J=1 and the clock running
    repeat (3) begin
      @(negedge clk); #1;
      chk("reset_qn", bus.qn, 1'b0);
      chk("reset_qn_bar", bus.qn_bar, 1'b1);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("release_set", bus.qn, 1'b1);

    // Set / hold / reset / hold from Q=0
    step_check(1'b0, 1'b1, 1'b0, "preclear");
    step_check(1'b1, 1'b0, 1'b1, "set");
    step_check(1'b0, 1'b0, 1'b1, "hold1");
    step_check(1'b0, 1'b1, 1'b0, "reset");
    step_check(1'b0, 1'b0, 1'b0, "hold0");

    // Toggle: exactly one change per clock
    step_check(1'b1, 1'b1, 1'b1, "toggle1");
    step_check(1'b1, 1'b1, 1'b0, "toggle2");
    step_check(1'b1, 1'b1, 1'b1, "toggle3");
    step_check(1'b1, 1'b1, 1'b0, "toggle4");

    // Sampling point: a J pulse confined to the low phase is ignored
    bus.s = 1'b0;
    bus.r = 1'b0;
    #2 bus.s = 1'b1;
    #4 bus.s = 1'b0;
    @(negedge clk); #1;
    chk("lowphase_pulse_ignored", bus.qn, 1'b0);
    bus.s = 1'b1;
    @(negedge clk); #1;
    chk("held_through_high", bus.qn, 1'b1);

    // Asynchronous reset pulse in the middle of the high phase
    @(posedge clk); #4;
    rst_n = 1'b0;
    #1;
    chk("async_reset_qn", bus.qn, 1'b0);
    chk("async_reset_qn_bar", bus.qn_bar, 1'b1);
    #1 rst_n = 1'b1;
    #1;
    chk("after_release_hold", bus.qn, 1'b0);
    @(negedge clk); #1;
    chk("after_release_apply", bus.qn, 1'b1);

    // Randomized J/K with occasional reset pulses in either phase
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      bus.s = 1'($urandom_range(0, 1));
      bus.r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rand_reset_high", bus.qn, 1'b0);
        #1 rst_n = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk); #3;
        bus.s = 1'($urandom_range(0, 1));
        bus.r = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) begin
          rst_n = 1'b0;
          #1;
          chk("rand_reset_low", bus.qn, 1'b0);
          #2 rst_n = 1'b1;
        end
      end
    end

    @(negedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
